// File: rtl/dm_access_arbiter_if.sv
// rtl/dm_access_arbiter_if.sv - two-requester access bus for the data memory arbiter
interface dm_access_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err
  );
endinterface

// File: rtl/dm_access_arbiter.sv
// rtl/dm_access_arbiter.sv - round-robin data memory arbiter with range check and array clear
module dm_access_arbiter #(
  parameter int          NWORDS    = 4096,
  parameter int          AW        = 12,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  dm_access_arbiter_if.slave  bus,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                mem_re,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [29:0]   MAX_IDX  = 30'(NWORDS - 1);
  localparam logic [AW-1:0] LAST_CNT = AW'(NWORDS - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          done_d, done_q;
  logic          rv0_q, rv1_q, err_q, rd_q;

  logic          arb_ok;
  logic          gnt0, gnt1, any_gnt;
  logic          sel_we;
  logic [31:0]   sel_addr, sel_wdata;
  logic [31:0]   offset;
  logic          legal;

  // Pick a winner: grants only in IDLE without a clear request; tie goes to the port not granted last
  always_comb begin
    arb_ok    = rst_n && (state_q == IDLE) && !clr_start;
    gnt0      = arb_ok && bus.p0_req && (!bus.p1_req || last_q);
    gnt1      = arb_ok && bus.p1_req && (!bus.p0_req || !last_q);
    any_gnt   = gnt0 || gnt1;
    sel_we    = gnt1 ? bus.p1_we    : bus.p0_we;
    sel_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
  end

  // Range/alignment check on the offset from the window base; comparing word index avoids any overflow
  always_comb begin
    offset = sel_addr - BASE_ADDR;
    legal  = (sel_addr >= BASE_ADDR) && (offset[1:0] == 2'b00) && (offset[31:2] <= MAX_IDX);
  end

  // Memory port mux: clear writes own the port in CLEAR, otherwise a legal granted access drives it
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
    end else if (any_gnt && legal) begin
      mem_re    = !sel_we;
      mem_we    = sel_we;
      mem_addr  = offset[AW+1:2];
      mem_wdata = sel_wdata;
    end
  end

  // Clear sequencer next state: walk every index once, then return to IDLE and flag completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    last_d  = last_q;
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and response registers; last-grant pointer resets to port 1 so port 0 wins first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
      rv0_q   <= gnt0;
      rv1_q   <= gnt1;
      err_q   <= any_gnt && !legal;
      rd_q    <= any_gnt && legal && !sel_we;
    end
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.p0_rvalid = rv0_q;
  assign bus.p1_rvalid = rv1_q;
  assign bus.p0_err    = rv0_q && err_q;
  assign bus.p1_err    = rv1_q && err_q;
  assign bus.p0_rdata  = (rv0_q && rd_q) ? mem_rdata : 32'h0;
  assign bus.p1_rdata  = (rv1_q && rd_q) ? mem_rdata : 32'h0;

  assign clr_busy = (state_q == CLEAR);
  assign clr_done = done_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb/tb_dm_access_arbiter.sv - directed self-checking bench for dm_access_arbiter
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        mem_re;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:4095];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dm_access_arbiter_if bus();

  dm_access_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Registered-read memory array behind the arbiter
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic issue(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_start = 1'b0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h8000_0000; bus.p0_wdata = 32'h1111_1111;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h8000_0004; bus.p1_wdata = 32'h0;
    #3;
    total++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {bus.p0_gnt, bus.p1_gnt}); else passed++;
    @(posedge clk); #1;
    total++; if ({bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err} !== 4'b0000)
      $display("FAIL reset_resp: got %b want 0000", {bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err}); else passed++;
    total++; if ({bus.p0_rdata, bus.p1_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h want 0", {bus.p0_rdata, bus.p1_rdata}); else passed++;
    total++; if ({clr_busy, clr_done} !== 2'b00) $display("FAIL reset_clr: got %b want 00", {clr_busy, clr_done}); else passed++;
    total++; if ({mem_re, mem_we, mem_addr, mem_wdata} !== 46'h0)
      $display("FAIL reset_mem: got re=%b we=%b addr=%h wdata=%h want all 0", mem_re, mem_we, mem_addr, mem_wdata); else passed++;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    logic       both;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h8000_0000; bus.p0_wdata = 32'h0;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h8000_0004; bus.p1_wdata = 32'h0;
    both = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2;
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
      if (bus.p0_gnt && bus.p1_gnt) both = 1'b1;
      total++; if ({bus.p0_gnt, bus.p1_gnt} !== exp)
        $display("FAIL rr_grant_%0d: got %b want %b", i, {bus.p0_gnt, bus.p1_gnt}, exp); else passed++;
      @(posedge clk); #1;
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    total++; if (both !== 1'b0) $display("FAIL rr_exclusive: got both=%b want 0", both); else passed++;
    total++; if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b01)
      $display("FAIL rr_rvalid: got %b want 01", {bus.p0_rvalid, bus.p1_rvalid}); else passed++;
    total++; if (bus.p1_rdata !== 32'hA5A5_0001) $display("FAIL rr_rdata: got %h want a5a50001", bus.p1_rdata); else passed++;
  endtask

  task automatic test_write_read();
    issue(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    total++; if ({bus.p0_gnt, mem_we, mem_re} !== 3'b110)
      $display("FAIL wr_strobe: got gnt/we/re=%b want 110", {bus.p0_gnt, mem_we, mem_re}); else passed++;
    total++; if (mem_addr !== 12'd4 || mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL wr_addr_data: got addr=%0d wdata=%h want 4 deadbeef", mem_addr, mem_wdata); else passed++;
    next_cycle();
    total++; if ({bus.p0_rvalid, bus.p0_err} !== 2'b10 || bus.p0_rdata !== 32'h0)
      $display("FAIL wr_resp: got rvalid/err=%b rdata=%h want 10 0", {bus.p0_rvalid, bus.p0_err}, bus.p0_rdata); else passed++;
    issue(0, 1'b0, 32'h8000_0010, 32'h0);
    total++; if ({bus.p0_gnt, mem_re, mem_we} !== 3'b110 || mem_addr !== 12'd4)
      $display("FAIL rd_strobe: got gnt/re/we=%b addr=%0d want 110 4", {bus.p0_gnt, mem_re, mem_we}, mem_addr); else passed++;
    next_cycle();
    total++; if ({bus.p0_rvalid, bus.p0_err} !== 2'b10) $display("FAIL rd_valid: got rvalid/err=%b want 10", {bus.p0_rvalid, bus.p0_err}); else passed++;
    total++; if (bus.p0_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", bus.p0_rdata); else passed++;
  endtask

  task automatic test_illegal();
    logic [31:0] bad [3];
    bad[0] = 32'h8000_0002;
    bad[1] = 32'h8000_4000;
    bad[2] = 32'h7FFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      issue(1, 1'b0, bad[i], 32'h0);
      total++; if ({bus.p1_gnt, mem_re, mem_we} !== 3'b100)
        $display("FAIL bad_gnt_%0d: got gnt/re/we=%b want 100", i, {bus.p1_gnt, mem_re, mem_we}); else passed++;
      next_cycle();
      total++; if ({bus.p1_rvalid, bus.p1_err} !== 2'b11 || bus.p1_rdata !== 32'h0)
        $display("FAIL bad_resp_%0d: got rvalid/err=%b rdata=%h want 11 0", i, {bus.p1_rvalid, bus.p1_err}, bus.p1_rdata); else passed++;
    end
  endtask

  task automatic test_clear();
    int bad;
    issue(0, 1'b1, 32'h8000_3FFC, 32'h0000_1234);
    total++; if ({mem_we, mem_addr} !== {1'b1, 12'd4095})
      $display("FAIL top_write: got we=%b addr=%0d want 1 4095", mem_we, mem_addr); else passed++;
    next_cycle();
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h8000_3FFC; bus.p0_wdata = 32'h0;
    clr_start = 1'b1;
    #2;
    total++; if ({bus.p0_gnt, mem_re, mem_we} !== 3'b000)
      $display("FAIL clr_priority: got gnt/re/we=%b want 000", {bus.p0_gnt, mem_re, mem_we}); else passed++;
    @(posedge clk); #1;
    clr_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if (i == 10) clr_start = 1'b1;
      if (i == 11) clr_start = 1'b0;
      #1;
      if (clr_busy !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 12'(i) ||
          mem_wdata !== 32'h0 || bus.p0_gnt !== 1'b0 || clr_done !== 1'b0) begin
        if (bad == 0)
          $display("FAIL clr_walk_%0d: got busy=%b we=%b addr=%0d wdata=%h gnt=%b done=%b want 1 1 %0d 0 0 0",
                   i, clr_busy, mem_we, mem_addr, mem_wdata, bus.p0_gnt, clr_done, i);
        bad++;
      end
      @(posedge clk); #1;
    end
    total++; if (bad !== 0) $display("FAIL clr_sequence: got %0d bad cycles want 0", bad); else passed++;
    #1;
    total++; if ({clr_busy, clr_done} !== 2'b01) $display("FAIL clr_done: got busy/done=%b want 01", {clr_busy, clr_done}); else passed++;
    total++; if ({bus.p0_gnt, mem_re} !== 2'b11 || mem_addr !== 12'd4095)
      $display("FAIL post_clr_gnt: got gnt/re=%b addr=%0d want 11 4095", {bus.p0_gnt, mem_re}, mem_addr); else passed++;
    next_cycle();
    total++; if ({bus.p0_rvalid, bus.p0_err} !== 2'b10 || bus.p0_rdata !== 32'h0)
      $display("FAIL clr_readback: got rvalid/err=%b rdata=%h want 10 0", {bus.p0_rvalid, bus.p0_err}, bus.p0_rdata); else passed++;
    total++; if (clr_done !== 1'b0) $display("FAIL clr_done_pulse: got %b want 0", clr_done); else passed++;
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
    end
    #1;
    total++; if ({clr_busy, mem_addr} !== {1'b1, 12'd100})
      $display("FAIL mid_clr_index: got busy=%b addr=%0d want 1 100", clr_busy, mem_addr); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({clr_busy, mem_we, mem_addr} !== 14'h0)
      $display("FAIL mid_clr_reset: got busy=%b we=%b addr=%0d want 0 0 0", clr_busy, mem_we, mem_addr); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL no_resume: got %0d cycles with busy/done set want 0", bad); else passed++;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    #1;
    total++; if ({clr_busy, mem_we, mem_addr} !== {2'b11, 12'd0})
      $display("FAIL restart_idx0: got busy=%b we=%b addr=%0d want 1 1 0", clr_busy, mem_we, mem_addr); else passed++;
    @(posedge clk); #2;
    total++; if (mem_addr !== 12'd1) $display("FAIL restart_idx1: got addr=%0d want 1", mem_addr); else passed++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    mem_rdata = 32'h0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_illegal();
    test_clear();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
